// File: rtl/pulse_stretch_mc.sv
// Multi-channel programmable pulse stretcher: each channel turns an edge or level
// trigger into an output pulse exactly len cycles long, with a done strobe at the end.
module pulse_stretch_mc #(
  parameter int unsigned CH     = 4,
  parameter int unsigned CNT_W  = 8,
  parameter string       PHASE  = "POSITIVE",
  parameter bit          EDGE   = 1'b1,
  parameter bit          RETRIG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] len,
  input  logic [CH-1:0]    d,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    done
);

  localparam bit            INV      = (PHASE == "NEGATIVE");
  localparam logic [CH-1:0] INV_MASK = {CH{INV}};

  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]    a_d_q, a_d_d;
  logic [CH-1:0]    q_q, q_d;
  logic [CH-1:0]    done_q, done_d;
  logic [CH-1:0]    a, trig, acc;

  // Per-channel trigger detection and counter next-state; the channel is active
  // exactly when its next count is non-zero, so only the output polarity is stored.
  always_comb begin
    a      = d ^ INV_MASK;
    a_d_d  = a;
    trig   = '0;
    acc    = '0;
    q_d    = INV_MASK;
    done_d = '0;
    for (int i = 0; i < int'(CH); i++) begin
      cnt_d[i] = cnt_q[i];
      trig[i]  = EDGE ? (a[i] & ~a_d_q[i]) : a[i];
      acc[i]   = trig[i] && (len != '0) && (RETRIG || (cnt_q[i] == '0));
      if (acc[i]) begin
        cnt_d[i] = len;
      end else if (cnt_q[i] > CNT_W'(1)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else if (cnt_q[i] == CNT_W'(1)) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b1;
      end
      q_d[i] = (cnt_d[i] != '0) ^ INV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) begin
        cnt_q[i] <= '0;
      end
      a_d_q  <= '0;
      q_q    <= INV_MASK;
      done_q <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      a_d_q  <= a_d_d;
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: three configurations driven in lockstep, expected
// outputs queued per cycle and checked one edge later, plus pulse-width checks.
module tb_pulse_stretch_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] len;
  logic [3:0] d_a, d_b, d_c;
  logic [3:0] q_a, q_b, q_c, done_a, done_b, done_c;

  always #5 clk = ~clk;

  // A: edge, active-high, retrigger.  B: level, active-high, no retrigger.
  // C: edge, active-low, no retrigger.
  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("POSITIVE"), .EDGE(1'b1), .RETRIG(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .len(len), .d(d_a), .q(q_a), .done(done_a));
  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("POSITIVE"), .EDGE(1'b0), .RETRIG(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .len(len), .d(d_b), .q(q_b), .done(done_b));
  pulse_stretch_mc #(.CH(4), .CNT_W(8), .PHASE("NEGATIVE"), .EDGE(1'b1), .RETRIG(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .len(len), .d(d_c), .q(q_c), .done(done_c));

  typedef struct {
    logic [3:0] q [3];
    logic [3:0] done [3];
  } exp_t;

  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         rem [3][4];
  logic [3:0] prev_a [3];
  logic [3:0] m_done [3];
  int         hi_a0 = 0;
  int         hi_a1 = 0;
  int         done_a0 = 0;

  // Reference: remaining-cycles per channel, idle when zero.
  task automatic model(input int k, input logic [3:0] act_in, input logic [7:0] l,
                       input logic r, input bit edge_mode, input bit retrig);
    for (int i = 0; i < 4; i++) begin
      bit fire;
      m_done[k][i] = 1'b0;
      if (!r) begin
        rem[k][i] = 0;
      end else begin
        fire = edge_mode ? (act_in[i] && !prev_a[k][i]) : act_in[i];
        if (fire && l != 0 && (retrig || rem[k][i] == 0)) begin
          rem[k][i] = int'(l);
        end else if (rem[k][i] > 0) begin
          rem[k][i] = rem[k][i] - 1;
          if (rem[k][i] == 0) m_done[k][i] = 1'b1;
        end
      end
    end
    prev_a[k] = r ? act_in : 4'b0000;
  endtask

  function automatic logic [3:0] active_bits(input int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (rem[k][i] != 0);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive logical-active stimulus, queue the expected post-edge outputs, check.
  task automatic step(input logic [3:0] aa, input logic [3:0] ab, input logic [3:0] ac,
                      input logic [7:0] l, input logic r);
    exp_t e;
    exp_t got;
    rst_n = r;
    len   = l;
    d_a   = aa;
    d_b   = ab;
    d_c   = ~ac;
    model(0, aa, l, r, 1'b1, 1'b1);
    model(1, ab, l, r, 1'b0, 1'b0);
    model(2, ac, l, r, 1'b1, 1'b0);
    e.q[0] = active_bits(0);
    e.q[1] = active_bits(1);
    e.q[2] = ~active_bits(2);
    for (int k = 0; k < 3; k++) e.done[k] = m_done[k];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("q_a", q_a, got.q[0]);
    chk("done_a", done_a, got.done[0]);
    chk("q_b", q_b, got.q[1]);
    chk("done_b", done_b, got.done[1]);
    chk("q_c", q_c, got.q[2]);
    chk("done_c", done_c, got.done[2]);
    if (q_a[0]) hi_a0++;
    if (q_a[1]) hi_a1++;
    if (done_a[0]) done_a0++;
  endtask

  task automatic idle(input int n, input logic [7:0] l);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 4'h0, l, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      prev_a[k] = '0;
      m_done[k] = '0;
      for (int i = 0; i < 4; i++) rem[k][i] = 0;
    end
    rst_n = 1'b0; len = 8'd0; d_a = '0; d_b = '0; d_c = '1;

    // Reset with inputs inactive (C sees d=1111, q must read 1111).
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 4'h0, 8'd5, 1'b0);
    chk("reset_q_c", q_c, 4'b1111);
    chk("reset_q_a", q_a, 4'b0000);

    // Single pulse, len=5: five active cycles, one done.
    hi_a0 = 0; done_a0 = 0;
    step(4'h1, 4'h0, 4'h0, 8'd5, 1'b1);
    idle(8, 8'd5);
    chk("width_len5", 4'(hi_a0), 4'd5);
    chk("done_len5", 4'(done_a0), 4'd1);

    // Retrigger on ch1 (A reloads, C ignores second pulse).
    step(4'h2, 4'h0, 4'h2, 8'd4, 1'b1);
    step(4'h0, 4'h0, 4'h0, 8'd4, 1'b1);
    step(4'h2, 4'h0, 4'h2, 8'd4, 1'b1);
    idle(8, 8'd4);

    // Level held 10 cycles on B ch2, no retrigger, len=3.
    for (int i = 0; i < 10; i++) step(4'h0, 4'h4, 4'h0, 8'd3, 1'b1);
    idle(5, 8'd3);

    // Active-low pulse on C ch3, len=2.
    step(4'h0, 4'h0, 4'h8, 8'd2, 1'b1);
    idle(4, 8'd2);

    // len=0 trigger on every channel: nothing starts.
    step(4'hF, 4'hF, 4'hF, 8'd0, 1'b1);
    idle(3, 8'd0);

    // Simultaneous triggers, len changed mid-stretch.
    hi_a0 = 0;
    step(4'hF, 4'hF, 4'hF, 8'd5, 1'b1);
    idle(8, 8'd2);
    chk("width_len_change", 4'(hi_a0), 4'd5);

    // Maximum length.
    hi_a0 = 0; done_a0 = 0;
    step(4'h1, 4'h0, 4'h0, 8'd255, 1'b1);
    idle(258, 8'd255);
    chk("width_len255", 8'(hi_a0), 8'd255);
    chk("done_len255", 4'(done_a0), 4'd1);

    // Reset in the 4th active cycle, then a full stretch.
    step(4'h2, 4'h0, 4'h0, 8'd10, 1'b1);
    idle(3, 8'd10);
    step(4'h0, 4'h0, 4'h0, 8'd10, 1'b0);
    chk("abort_q_a", q_a, 4'b0000);
    idle(3, 8'd10);
    hi_a1 = 0;
    step(4'h2, 4'h0, 4'h0, 8'd10, 1'b1);
    idle(13, 8'd10);
    chk("width_after_reset", 4'(hi_a1), 4'd10);

    // Random traffic on all three configurations.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] l;
      case ($urandom_range(0, 4))
        0: l = 8'd0;
        1: l = 8'd1;
        2: l = 8'd2;
        3: l = 8'd3;
        default: l = 8'd7;
      endcase
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), l, ($urandom_range(0, 40) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_mc.md
Name: pulse_stretch_mc

Overview:
Multi-channel, run-time programmable pulse stretcher. It is the parametrised successor of the team's fixed-length broaden block. Each of CH independent channels turns a short or level trigger into an output pulse of exactly len clock cycles, with selectable polarity, trigger type (edge or level) and retrigger policy. It sits between fast event sources (strobes, interrupt flags, error ticks) and slow consumers such as LEDs, cross-domain synchronisers and status registers.

Parameters:
CH, 4, number of independent channels (>=1)
CNT_W, 8, width of the length counter; maximum stretch is 2^CNT_W-1 cycles
PHASE, "POSITIVE", "POSITIVE" means active-high in/out; "NEGATIVE" means active-low in/out
EDGE, 1, 1 triggers on the inactive->active transition of d; 0 triggers on the active level of d
RETRIG, 1, 1 reloads the counter on a trigger while active; 0 ignores triggers while active

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous reset, active-low
len  input  CNT_W  stretch length in cycles, shared by all channels, sampled only at trigger
d  input  CH  per-channel trigger inputs, polarity per PHASE
q  output  CH  per-channel stretched outputs, polarity per PHASE, registered
done  output  CH  one-cycle active-high pulse per channel when its stretch ends

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk. No asynchronous paths.
- Normalisation: inv = (PHASE=="NEGATIVE"). Internal active signal a[i] = d[i]^inv. Output q[i] = act[i]^inv, where act[i] is a register.
- Reset (rst_n=0 at a clk edge):
  - cnt[i]=0, act[i]=0, done[i]=0.
  - a_d[i]=0, where a_d is the registered copy of a[i].
  - q reads 0 for POSITIVE and all-ones for NEGATIVE.
  - Reset mid-stretch aborts the stretch immediately, with no done pulse.
- First sample after reset: a_d=0, so in edge mode a d already active on the first post-reset cycle counts as an edge.
- Trigger: trig[i] = EDGE ? (a[i] & ~a_d[i]) : a[i], evaluated every cycle.
- Accept rule: acc[i] = trig[i] & (len!=0) & (RETRIG | cnt[i]==0).
- Per-channel counter update, in priority order:
  - acc: cnt<=len, act<=1.
  - cnt>1: cnt<=cnt-1, act<=1.
  - cnt==1: cnt<=0, act<=0, done<=1.
  - otherwise: hold at 0, act<=0.
  - done is 0 in every cycle except the single cycle after cnt goes 1->0 without an accept.
- Latency: trigger sampled at edge t gives q active from edge t, i.e. visible in cycle t+1. q stays active for exactly len cycles. done is active in the first inactive cycle.
- Retrigger (RETRIG=1):
  - An accept while active reloads cnt to the current len. q stays continuously active with no gap, and no done is issued for the interrupted stretch.
  - Level mode with a held active: q is active while held, plus len cycles after release.
- No retrigger (RETRIG=0):
  - Triggers are ignored while cnt!=0.
  - A trigger coinciding with cnt==1 is ignored; cnt reaches 0 and done fires.
  - Level mode with a held active: q runs len cycles on, 1 cycle off (that cycle also carries done), then repeats.
- Length rules:
  - len is sampled only at accept; changes during a stretch do not affect it.
  - len==0: triggers are not accepted and the channel stays idle. An in-flight stretch still completes.
  - len=2^CNT_W-1 must work, with no overflow or wrap.
- Independence: channels share only len. Simultaneous triggers on all channels are all accepted in the same cycle.

Test Plan:
- Edge, POSITIVE, RETRIG=1, len=5, one-cycle d[0] pulse at cycle 10 -> q[0]=1 during cycles 11..15, done[0]=1 in cycle 16, q[1..3]=0 throughout.
- Retrigger: len=4, d[1] pulses at cycles 10 and 12 -> q[1] continuously 1 during cycles 11..16, single done[1] in cycle 17. Same stimulus with RETRIG=0 -> q[1] active 11..14, done in 15, second pulse ignored.
- Level, RETRIG=0, len=3, d[2] held high for 10 cycles from cycle 20 -> q[2] pattern 1,1,1,0,1,1,1,0,1,1 from cycle 21, done in each 0 cycle.
- NEGATIVE phase, len=2, reset released with d=4'b1111 -> q=4'b1111. d[3] low for one cycle at cycle 30 -> q[3]=0 during 31..32, back to 1 in 33.
- Boundaries: len=0 with a trigger -> no output. len=255 (CNT_W=8) -> 255 active cycles. len changed from 5 to 2 mid-stretch -> stretch still 5 cycles.
- Reset mid-stretch: len=10, rst_n=0 at the 4th active cycle -> q inactive from the next cycle, no done, next trigger after release gives a full 10-cycle stretch.
